// File: rtl/ifu_prefetch.sv
// Purpose : instruction-fetch prefetch queue between a wait-stated 16-bit instruction memory and decode.
// Latency : mem_ack in cycle N -> instr_valid in N+1 (same cycle with IFU_BYPASS_EN when the queue is empty).
// Backpressure: no request is issued while the queue is full; the core drains it with consume.
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   redirect, redirect_pc   - flush queue and restart fetch at redirect_pc (bit 0 forced to 0)
//   consume                 - core pops the head entry (ignored when instr_valid=0)
//   instr, instr_pc         - head instruction and its address (combinational from head storage)
//   instr_valid             - head entry valid
//   mem_req, mem_addr       - single outstanding read request to instruction memory
//   mem_ack, mem_rdata      - read completion and data
//
// Build option: define IFU_BYPASS_EN to forward acked data straight to the outputs when the
// queue is empty (zero-latency path from mem_ack/mem_rdata to instr/instr_pc/instr_valid).

module ifu_prefetch #(
   parameter int DEPTH = 4,
   parameter int AW    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          consume,
   output logic [15:0]   instr,
   output logic [AW-1:0] instr_pc,
   output logic          instr_valid,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [15:0]   mem_rdata
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [AW-1:0] fetch_pc;
   logic [AW-1:0] fetch_pc_nxt;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_nxt;

   logic [AW-1:0] pc_mem  [DEPTH];
   logic [15:0]   ins_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   logic          ack_ok;
   logic          bypass_hit;
   logic          bypass_take;
   logic          push;
   logic          pop;

   // ------------------------------------------------------------------
   // Datapath control
   // ------------------------------------------------------------------

   // An ack only counts while a live request is outstanding; acks in IDLE
   // are protocol violations and acks in DRAIN belong to an abandoned fetch.
   assign ack_ok = (state == REQ) && mem_ack && !redirect;

`ifdef IFU_BYPASS_EN
   // Empty queue: hand the returning word straight to the core. If the core
   // takes it in the same cycle it never enters the queue.
   assign bypass_hit  = ack_ok && (count == '0);
   assign bypass_take = bypass_hit && consume;
`else
   assign bypass_hit  = 1'b0;
   assign bypass_take = 1'b0;
`endif

   assign push = ack_ok && !bypass_take;
   assign pop  = consume && (count != '0) && !redirect;

   always_comb begin
      count_nxt    = count;
      fetch_pc_nxt = fetch_pc;
      if (redirect) begin
         count_nxt    = '0;
         // Masking instead of slicing keeps every bit of redirect_pc in use.
         fetch_pc_nxt = redirect_pc & ~AW'(1);
      end else begin
         count_nxt = count + CW'(push) - CW'(pop);
         if (ack_ok) begin
            fetch_pc_nxt = fetch_pc + AW'(2);
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!redirect && (count < DEPTH_C)) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               // Acked in the redirect cycle: nothing left outstanding.
               state_nxt = mem_ack ? IDLE : DRAIN;
            end else if (mem_ack) begin
               state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
            end
         end
         DRAIN: begin
            if (mem_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The request address must not move while a discarded fetch is draining,
   // even though fetch_pc already holds the new target.
   assign addr_nxt = (state_nxt == DRAIN) ? addr_q : fetch_pc_nxt;

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      mem_req     = (state != IDLE);
      mem_addr    = addr_q;
      instr_valid = (count != '0) || bypass_hit;
      instr       = ins_mem[rd_ptr];
      instr_pc    = pc_mem[rd_ptr];
      if (bypass_hit) begin
         instr    = mem_rdata;
         instr_pc = fetch_pc;
      end
   end

   // ------------------------------------------------------------------
   // Fetch PC, request address, pointers and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= '0;
         addr_q   <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         addr_q   <= addr_nxt;
         count    <= count_nxt;
         if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end
   end

   // Storage is reset so the stale head reads as zero straight after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]  <= '0;
            ins_mem[i] <= '0;
         end
      end else if (push) begin
         pc_mem[wr_ptr]  <= fetch_pc;
         ins_mem[wr_ptr] <= mem_rdata;
      end
   end

endmodule
